macro_cmd_scheduler: RTL

//  In-order command scheduler between the host and Macro_controller. Host ExLdSt and Compute commands enter one FIFO.

---
 rtl/macro_sched_pkg.sv | 60 ++++++
 rtl/macro_sched_fifo.sv | 61 ++++++
 rtl/macro_cmd_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/macro_sched_pkg.sv
// Purpose: shared types and field positions for the macro command scheduler.
// Contents: compute command field indices, mode/len encodings, FSM states,
//           and the FIFO entry layout plus the load/store hazard check.
package macro_sched_pkg;

  localparam int ADDR_W  = 6;
  localparam int ROW_NUM = 16;
  localparam int CMD_W   = 25;

  // Compute command layout: {spec, mode[2:0], len[2:0], rs1, rs2, rd}
  localparam int SPEC_BIT = 24;
  localparam int MODE_HI  = 23;
  localparam int MODE_LO  = 21;
  localparam int LEN_HI   = 20;
  localparam int LEN_LO   = 18;
  localparam int RS1_HI   = 17;
  localparam int RS1_LO   = 12;
  localparam int RS2_HI   = 11;
  localparam int RS2_LO   = 6;
  localparam int RD_HI    = 5;
  localparam int RD_LO    = 0;

  typedef enum logic [2:0] {
    MODE_AND = 3'b010,
    MODE_MUL = 3'b111
  } mode_e;

  typedef enum logic [2:0] {
    LEN_INT8 = 3'b010
  } len_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY
  } fsm_e;

  typedef struct packed {
    logic                is_comp;
    logic [CMD_W-1:0]    cmd;
    logic [ROW_NUM-1:0]  wdata;
  } entry_t;

  // Stores conflict with any row the compute reads or writes (WAR/WAW);
  // loads only conflict with the row the compute writes (RAW).
  function automatic logic ldst_hazard(input logic [CMD_W-1:0] comp_cmd,
                                       input logic [ADDR_W:0]  ldst_cmd);
    logic [ADDR_W-1:0] addr;
    logic              wr;
    addr = ldst_cmd[ADDR_W-1:0];
    wr   = ldst_cmd[ADDR_W];
    if (wr) begin
      return (addr == comp_cmd[RS1_HI:RS1_LO]) ||
             (addr == comp_cmd[RS2_HI:RS2_LO]) ||
             (addr == comp_cmd[RD_HI:RD_LO]);
    end
    return addr == comp_cmd[RD_HI:RD_LO];
  endfunction

endpackage

// File: rtl/macro_sched_fifo.sv
// Purpose: synchronous FIFO of scheduler entries with full/empty flags.
// Ports: push_i/entry_i write side, pop_i/head_o read side (head valid when !empty_o).
// Latency: entry visible at head the cycle after its push edge; push when full is dropped.
module macro_sched_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  macro_sched_pkg::entry_t entry_i,
  input  logic                    pop_i,
  output macro_sched_pkg::entry_t head_o,
  output logic                    full_o,
  output logic                    empty_o
);
  import macro_sched_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/macro_cmd_scheduler.sv
// Purpose: in-order scheduler of host ExLdSt/Compute commands onto the macro,
//          letting independent load/stores overlap a running compute.
// Ports: host_* command push and read return; mac_ldst_* one-cycle strobe;
//        mac_comp_* valid/ready compute issue; hazard_stall and busy status.
module macro_cmd_scheduler #(
  parameter int DEPTH   = 4,
  parameter int ROW_NUM = 16,
  parameter int ADDR_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic               host_is_comp,
  input  logic [24:0]        host_cmd,
  input  logic [ROW_NUM-1:0] host_wdata,
  output logic [ROW_NUM-1:0] host_rdata,
  output logic               host_rvalid,
  output logic               mac_ldst_valid,
  output logic [ADDR_W:0]    mac_ldst_cmd,
  output logic [ROW_NUM-1:0] mac_ldst_wdata,
  input  logic [ROW_NUM-1:0] mac_ldst_rdata,
  output logic               mac_comp_valid,
  input  logic               mac_comp_ready,
  output logic [24:0]        mac_comp_cmd,
  output logic               hazard_stall,
  output logic               busy
);
  import macro_sched_pkg::*;

  entry_t             push_entry;
  entry_t             head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               head_vld;
  logic               inflight;
  logic               hazard;
  logic               issue_comp;
  logic               issue_ldst;
  logic               pop;

  fsm_e               state_q;
  logic               comp_vld_q;
  logic [24:0]        comp_cmd_q;
  logic               ready_q;

  logic               ldst_vld_q,   ldst_vld_d;
  logic [ADDR_W:0]    ldst_cmd_q,   ldst_cmd_d;
  logic [ROW_NUM-1:0] ldst_wdata_q, ldst_wdata_d;
  logic               rvalid_q,     rvalid_d;
  logic [ROW_NUM-1:0] rdata_q,      rdata_d;

  assign push_entry = '{is_comp: host_is_comp, cmd: host_cmd, wdata: host_wdata};

  macro_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (host_valid),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue decisions look only at the head; order is strict, so a blocked
  // head blocks everything behind it.
  assign head_vld     = !fifo_empty;
  assign inflight     = (state_q != IDLE);
  assign hazard       = inflight && ldst_hazard(comp_cmd_q, head.cmd[ADDR_W:0]);
  assign issue_comp   = head_vld && head.is_comp && (state_q == IDLE);
  assign issue_ldst   = head_vld && !head.is_comp && !hazard;
  assign pop          = issue_comp || issue_ldst;
  assign hazard_stall = head_vld && !head.is_comp && hazard;

  assign host_ready = !fifo_full;
  assign busy       = head_vld || inflight;

  // Completion is the first cycle ready is seen high again after the macro
  // dropped it following the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      comp_vld_q <= 1'b0;
      comp_cmd_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= mac_comp_ready;
      case (state_q)
        IDLE: begin
          if (issue_comp) begin
            state_q    <= ISSUE;
            comp_vld_q <= 1'b1;
            comp_cmd_q <= head.cmd;
          end
        end
        ISSUE: begin
          if (mac_comp_ready) begin
            state_q    <= BUSY;
            comp_vld_q <= 1'b0;
          end
        end
        BUSY: begin
          if (mac_comp_ready && !ready_q) state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          comp_vld_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ldst_vld_d   = issue_ldst;
    ldst_cmd_d   = ldst_cmd_q;
    ldst_wdata_d = ldst_wdata_q;
    if (issue_ldst) begin
      ldst_cmd_d   = head.cmd[ADDR_W:0];
      ldst_wdata_d = head.wdata;
    end
    // Read data is captured at the edge that ends a load strobe.
    rvalid_d = ldst_vld_q && !ldst_cmd_q[ADDR_W];
    rdata_d  = rvalid_d ? mac_ldst_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldst_vld_q   <= 1'b0;
      ldst_cmd_q   <= '0;
      ldst_wdata_q <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      ldst_vld_q   <= ldst_vld_d;
      ldst_cmd_q   <= ldst_cmd_d;
      ldst_wdata_q <= ldst_wdata_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mac_ldst_valid = ldst_vld_q;
  assign mac_ldst_cmd   = ldst_cmd_q;
  assign mac_ldst_wdata = ldst_wdata_q;
  assign mac_comp_valid = comp_vld_q;
  assign mac_comp_cmd   = comp_cmd_q;
  assign host_rvalid    = rvalid_q;
  assign host_rdata     = rdata_q;

endmodule
